// File: rtl/drive_sequencer_unit.sv
// Multi-bank drive-path sequencer: per-bank envelope burst / virtual-Z FSMs joined by a
// global completion barrier, with a watchdog that recovers from stalled envelope memories.
module drive_sequencer_unit #(
    parameter int NUM_BANK                  = 2,
    parameter int NUM_QUBIT_PER_BANK        = 16,
    parameter int QUBIT_ADDR_WIDTH_PER_BANK = 4,
    parameter int ENV_ADDR_WIDTH            = 10,
    parameter int ENV_LEN_WIDTH             = 8,
    parameter int TIMEOUT_CYCLES            = 1024
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          trigger,
    input  logic [NUM_BANK-1:0]                           bank_en,
    input  logic [NUM_BANK-1:0]                           inst_valid,
    input  logic [NUM_BANK-1:0]                           inst_is_rz,
    input  logic [NUM_BANK*QUBIT_ADDR_WIDTH_PER_BANK-1:0] inst_qubit_sel,
    input  logic [NUM_BANK*ENV_ADDR_WIDTH-1:0]            inst_env_base,
    input  logic [NUM_BANK*ENV_LEN_WIDTH-1:0]             inst_env_len,
    input  logic [NUM_BANK-1:0]                           env_ready,
    output logic [NUM_BANK-1:0]                           env_rd_en,
    output logic [NUM_BANK*ENV_ADDR_WIDTH-1:0]            env_addr,
    output logic [NUM_BANK-1:0]                           busy,
    output logic [NUM_BANK*NUM_QUBIT_PER_BANK-1:0]        nco_phase_wr_en,
    output logic [NUM_BANK*NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_wr_en,
    output logic [NUM_BANK*NUM_QUBIT_PER_BANK-1:0]        nco_z_corr_mode,
    output logic                                          update_pc,
    output logic                                          timeout_err
);
    localparam int QW   = QUBIT_ADDR_WIDTH_PER_BANK;
    localparam int NQ   = NUM_QUBIT_PER_BANK;
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) + 1 : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [2:0] {IDLE, PLAY, COMMIT, RZ, DONE} bank_state_t;
    typedef enum logic {G_IDLE, G_RUN} g_state_t;

    g_state_t            g_state_reg;
    logic [WD_W-1:0]     wd_reg;
    logic [NUM_BANK-1:0] done_vec;
    logic                all_done;
    logic                start;
    logic                wd_hit;

    assign all_done  = &done_vec;
    assign start     = (g_state_reg == G_IDLE) && trigger;
    assign update_pc = (g_state_reg == G_RUN) && all_done;
    // The barrier wins over the watchdog so banks already heading to IDLE are not re-forced.
    assign wd_hit    = (TIMEOUT_CYCLES != 0) && (g_state_reg == G_RUN) && !all_done
                       && (wd_reg == WD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            g_state_reg <= G_IDLE;
            wd_reg      <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (g_state_reg)
                G_IDLE: begin
                    wd_reg <= '0;
                    if (trigger) g_state_reg <= G_RUN;
                end
                G_RUN: begin
                    if (update_pc) begin
                        g_state_reg <= G_IDLE;
                        wd_reg      <= '0;
                    end else begin
                        wd_reg <= wd_reg + WD_W'(1);
                    end
                    if (wd_hit) timeout_err <= 1'b1;
                end
                default: g_state_reg <= G_IDLE;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_BANK; gi++) begin : g_bank
            bank_state_t               state_reg;
            logic [ENV_ADDR_WIDTH-1:0] addr_reg;
            logic [ENV_LEN_WIDTH-1:0]  remain_reg;
            logic [QW-1:0]             qubit_reg;
            logic [NQ-1:0]             qubit_onehot;
            logic [ENV_LEN_WIDTH-1:0]  len_in;

            assign len_in = inst_env_len[gi*ENV_LEN_WIDTH +: ENV_LEN_WIDTH];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_reg  <= IDLE;
                    addr_reg   <= '0;
                    remain_reg <= '0;
                    qubit_reg  <= '0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            if (start) begin
                                qubit_reg  <= inst_qubit_sel[gi*QW +: QW];
                                addr_reg   <= inst_env_base[gi*ENV_ADDR_WIDTH +: ENV_ADDR_WIDTH];
                                // A zero length still plays one sample.
                                remain_reg <= (len_in == '0) ? ENV_LEN_WIDTH'(1) : len_in;
                                if (!bank_en[gi] || !inst_valid[gi]) state_reg <= DONE;
                                else if (inst_is_rz[gi])             state_reg <= RZ;
                                else                                 state_reg <= PLAY;
                            end
                        end
                        PLAY: begin
                            if (wd_hit) begin
                                state_reg <= DONE;
                            end else if (env_ready[gi]) begin
                                addr_reg <= addr_reg + ENV_ADDR_WIDTH'(1);
                                if (remain_reg == ENV_LEN_WIDTH'(1)) state_reg <= COMMIT;
                                else remain_reg <= remain_reg - ENV_LEN_WIDTH'(1);
                            end
                        end
                        COMMIT:  state_reg <= DONE;
                        RZ:      state_reg <= DONE;
                        DONE:    if (update_pc) state_reg <= IDLE;
                        default: state_reg <= IDLE;
                    endcase
                end
            end

            assign qubit_onehot = NQ'(1) << qubit_reg;
            assign done_vec[gi]  = (state_reg == DONE);
            assign env_rd_en[gi] = (state_reg == PLAY);
            assign busy[gi]      = (state_reg == PLAY) || (state_reg == COMMIT) || (state_reg == RZ);
            assign env_addr[gi*ENV_ADDR_WIDTH +: ENV_ADDR_WIDTH] =
                (state_reg == PLAY) ? addr_reg : '0;
            assign nco_phase_wr_en[gi*NQ +: NQ]  = (state_reg == RZ) ? qubit_onehot : '0;
            assign nco_z_corr_wr_en[gi*NQ +: NQ] = (state_reg == COMMIT) ? qubit_onehot : '0;
            assign nco_z_corr_mode[gi*NQ +: NQ]  =
                ((state_reg == PLAY) || (state_reg == COMMIT)) ? qubit_onehot : '0;
        end
    endgenerate
endmodule
